ring_phase_monitor: RTL and testbench

Downstream consumer of the 4-stage one-hot ring counter. It samples the ring outputs, checks that the one-hot pattern is legal and advances in the correct order, and acquires lock after a run of correct steps. It then reports the binary phase index and a full-rotation count. Any corruption of the ring raises a sticky error until software-style clear.

---
 rtl/ring_phase_monitor.sv | 147 ++++++++++++++
 tb/tb_ring_phase_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring counter, locks onto it, counts rotations, flags faults.
// Optional stall detection in TRACK is built when RING_MON_STALL_CHECK_EN is defined.
module ring_phase_monitor #(
    parameter int WIDTH     = 4,
    parameter int CNT_W     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int STALL_MAX = 16,
    localparam int IW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ph_valid,
    input  logic [WIDTH-1:0] ph,
    input  logic             clr_err,
    output logic [IW-1:0]    phase_idx,
    output logic             phase_ok,
    output logic             locked,
    output logic [CNT_W-1:0] rot_cnt,
    output logic             rot_tick,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    typedef enum logic [1:0] {SEARCH, TRACK, FAULT} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] phase_idx_q, phase_idx_d, new_idx, succ_idx;
    logic [CNT_W-1:0] rot_cnt_q, rot_cnt_d;
    logic [GW-1:0] good_q, good_d;
    logic [1:0] err_code_q, err_code_d;
    logic phase_ok_q, phase_ok_d, rot_tick_q, rot_tick_d, prev_vld_q, prev_vld_d;
    logic onehot, succ_ok;
`ifdef RING_MON_STALL_CHECK_EN
    localparam int SW = $clog2(STALL_MAX + 1);
    logic [SW-1:0] stall_q, stall_d;
`else
    localparam logic unused_stall_max = STALL_MAX > 0;
`endif
    // decode the sample into an index and check it against the expected successor
    always_comb begin
        onehot = $onehot(ph);
        new_idx = '0;
        for (int i = 0; i < WIDTH; i++) new_idx = ph[i] ? IW'(i) : new_idx;
        succ_idx = (phase_idx_q == LAST) ? '0 : phase_idx_q + IW'(1);
        succ_ok = new_idx == succ_idx;
    end
    // SEARCH / TRACK / FAULT next-state and output update
    always_comb begin
        state_d = state_q;
        phase_idx_d = phase_idx_q;
        phase_ok_d = phase_ok_q;
        rot_cnt_d = rot_cnt_q;
        rot_tick_d = 1'b0;
        err_code_d = err_code_q;
        good_d = good_q;
        prev_vld_d = prev_vld_q;
`ifdef RING_MON_STALL_CHECK_EN
        stall_d = '0;
`endif
        case (state_q)
            SEARCH: begin
                if (ph_valid && onehot) begin
                    phase_idx_d = new_idx;
                    phase_ok_d = 1'b1;
                    prev_vld_d = 1'b1;
                    good_d = (prev_vld_q && succ_ok) ? good_q + GW'(1) : '0;
                    if (good_d == GW'(LOCK_CNT)) begin
                        state_d = TRACK;
                        good_d = '0;
                    end
                end else if (ph_valid) begin
                    phase_ok_d = 1'b0;
                    good_d = '0;
                    prev_vld_d = 1'b0;
                end
            end
            TRACK: begin
                if (ph_valid && !onehot) begin
                    state_d = FAULT;
                    err_code_d = 2'b01;
                    phase_ok_d = 1'b0;
                end else if (ph_valid && !succ_ok) begin
                    state_d = FAULT;
                    err_code_d = 2'b10;
                end else if (ph_valid) begin
                    phase_idx_d = new_idx;
                    phase_ok_d = 1'b1;
                    rot_tick_d = phase_idx_q == LAST;
                    rot_cnt_d = rot_cnt_q + CNT_W'(rot_tick_d);
                end
`ifdef RING_MON_STALL_CHECK_EN
                else if (stall_q + SW'(1) == SW'(STALL_MAX)) begin
                    state_d = FAULT;
                    err_code_d = 2'b11;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
`endif
            end
            FAULT: begin
                if (clr_err) begin
                    state_d = SEARCH;
                    err_code_d = 2'b00;
                    rot_cnt_d = '0;
                    good_d = '0;
                    prev_vld_d = 1'b0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end
    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            phase_idx_q <= '0;
            phase_ok_q <= 1'b0;
            rot_cnt_q <= '0;
            rot_tick_q <= 1'b0;
            err_code_q <= 2'b00;
            good_q <= '0;
            prev_vld_q <= 1'b0;
`ifdef RING_MON_STALL_CHECK_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_idx_q <= phase_idx_d;
            phase_ok_q <= phase_ok_d;
            rot_cnt_q <= rot_cnt_d;
            rot_tick_q <= rot_tick_d;
            err_code_q <= err_code_d;
            good_q <= good_d;
            prev_vld_q <= prev_vld_d;
`ifdef RING_MON_STALL_CHECK_EN
            stall_q <= stall_d;
`endif
        end
    end
    assign phase_idx = phase_idx_q;
    assign phase_ok = phase_ok_q;
    assign locked = state_q == TRACK;
    assign rot_cnt = rot_cnt_q;
    assign rot_tick = rot_tick_q;
    assign err = state_q == FAULT;
    assign err_code = err_code_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: scoreboard bench for ring_phase_monitor with a behavioural reference model.
module tb_ring_phase_monitor;
    localparam int W = 4, CW = 2, LC = 4, SM = 16;
    logic clk = 1'b0, rst = 1'b1, ph_valid = 1'b0, clr_err = 1'b0;
    logic [W-1:0] ph = '0;
    logic [1:0] phase_idx, err_code;
    logic [CW-1:0] rot_cnt;
    logic phase_ok, locked, rot_tick, err;

    ring_phase_monitor #(.WIDTH(W), .CNT_W(CW), .LOCK_CNT(LC), .STALL_MAX(SM)) dut (
        .clk(clk), .rst(rst), .ph_valid(ph_valid), .ph(ph), .clr_err(clr_err),
        .phase_idx(phase_idx), .phase_ok(phase_ok), .locked(locked), .rot_cnt(rot_cnt),
        .rot_tick(rot_tick), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic ok;
        logic lk;
        logic [CW-1:0] rot;
        logic tick;
        logic er;
        logic [1:0] code;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0, miscompares = 0;
    int ring_pos = 0;

    bit m_lock = 0, m_fault = 0, m_ok = 0, m_tick = 0;
    int m_idx = 0, m_rot = 0, m_code = 0, m_stall = 0;
    int hist[$];

    // reference model: SEARCH keeps the run of consecutive successor indices, locking at LC+1 entries
    task automatic model(input bit r, input bit v, input logic [W-1:0] p, input bit c);
        bit oh;
        int k;
        exp_t e;
        oh = $countones(p) == 1;
        k = 0;
        for (int i = 0; i < W; i++) if (p[i]) k = i;
        m_tick = 0;
        if (r) begin
            m_lock = 0; m_fault = 0; m_ok = 0; m_idx = 0; m_rot = 0; m_code = 0; m_stall = 0;
            hist.delete();
        end else if (m_fault) begin
            if (c) begin
                m_fault = 0; m_code = 0; m_rot = 0;
                hist.delete();
            end
        end else if (m_lock) begin
            if (v) begin
                m_stall = 0;
                if (!oh) begin
                    m_fault = 1; m_lock = 0; m_code = 1; m_ok = 0;
                end else if (k == (m_idx + 1) % W) begin
                    if (k == 0) begin
                        m_rot = (m_rot + 1) % (1 << CW);
                        m_tick = 1;
                    end
                    m_idx = k; m_ok = 1;
                end else begin
                    m_fault = 1; m_lock = 0; m_code = 2;
                end
            end else begin
`ifdef RING_MON_STALL_CHECK_EN
                m_stall++;
                if (m_stall == SM) begin
                    m_fault = 1; m_lock = 0; m_code = 3;
                end
`endif
            end
        end else if (v) begin
            if (oh) begin
                if (hist.size() > 0 && k != (hist[$] + 1) % W) hist.delete();
                hist.push_back(k);
                m_idx = k; m_ok = 1;
                if (hist.size() == LC + 1) begin
                    m_lock = 1; m_stall = 0;
                    hist.delete();
                end
            end else begin
                m_ok = 0;
                hist.delete();
            end
        end
        e.idx = 2'(m_idx);
        e.ok = m_ok;
        e.lk = m_lock;
        e.rot = CW'(m_rot);
        e.tick = m_tick;
        e.er = m_fault;
        e.code = 2'(m_code);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit v, input logic [W-1:0] p, input bit c);
        @(negedge clk);
        rst = r; ph_valid = v; ph = p; clr_err = c;
        model(r, v, p, c);
    endtask

    task automatic ring(input int n);
        logic [W-1:0] one;
        one = 1;
        repeat (n) begin
            cyc(0, 1, one << ring_pos, 0);
            ring_pos = (ring_pos + 1) % W;
        end
    endtask

    // monitor: compare every registered output set against the oldest expectation
    exp_t got, want;
    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = {phase_idx, phase_ok, locked, rot_cnt, rot_tick, err, err_code};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL vec%0d outputs: got idx=%0d ok=%0b lk=%0b rot=%0d tick=%0b err=%0b code=%0d, expected idx=%0d ok=%0b lk=%0b rot=%0d tick=%0b err=%0b code=%0d",
                         vectors, got.idx, got.ok, got.lk, got.rot, got.tick, got.er, got.code,
                         want.idx, want.ok, want.lk, want.rot, want.tick, want.er, want.code);
            end
        end
    end

    initial begin
        int r;
        logic [W-1:0] one;
        one = 1;
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        ring_pos = 0; ring(5);
        ring(20);
        cyc(0, 1, 4'b0011, 0);
        ring(2);
        cyc(0, 1, 4'b0001, 1);
        cyc(0, 0, '0, 0);
        ring_pos = 0; ring(6);
        cyc(0, 1, 4'b1000, 0);
        cyc(0, 0, '0, 1);
        ring_pos = 0; ring(6);
        cyc(0, 1, 4'b0010, 0);
        cyc(0, 0, '0, 1);
        ring_pos = 0; ring(17);
        cyc(1, 1, 4'b0010, 0);
        ring_pos = 0; ring(4);
        cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 0);
        ring(3);
        repeat (17) cyc(0, 0, '0, 0);
        cyc(0, 0, '0, 1);
        ring_pos = 0;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) < 9) begin
                cyc(r < 1, $urandom_range(0, 9) < 8, one << ring_pos, r >= 2 && r < 7);
                ring_pos = (ring_pos + 1) % W;
            end else begin
                cyc(r < 1, 1, W'($urandom), r >= 2 && r < 7);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
